// File: rtl/huff_pkg.sv
// ----------------------------------------------------------------------------
// huff_pkg
// Shared constants and types for the Huffman encoder and its job arbiter.
//   MAX_CHAR_COUNT : characters per job (must match the encoder build)
//   BIT_WIDTH      : width of one character
//   FREQ_W         : width of one frequency
//   arb_state_t    : job arbiter FSM states
//   huff_job_t     : one job as handed to the encoder (characters + freqs)
// ----------------------------------------------------------------------------
package huff_pkg;

    localparam int MAX_CHAR_COUNT = 3;
    localparam int BIT_WIDTH      = 8;
    localparam int FREQ_W         = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [MAX_CHAR_COUNT-1:0][BIT_WIDTH-1:0] data;
        logic [MAX_CHAR_COUNT-1:0][FREQ_W-1:0]    freq;
    } huff_job_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping past NUM_REQ-1 back to 0.
//   req_i       : request vector
//   ptr_i       : highest-priority index for this pick (0..NUM_REQ-1)
//   gnt_o       : one-hot grant (zero when no request)
//   gnt_idx_o   : index of the granted request
//   gnt_valid_o : at least one request is asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_valid_o
);

    int          idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_w = ID_W'(idx);
            if (!gnt_valid_o && req_i[idx_w]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = idx_w;
                gnt_o       = NUM_REQ'(1) << idx_w;
            end
        end
    end

endmodule

// File: rtl/huff_job_arbiter.sv
// ----------------------------------------------------------------------------
// huff_job_arbiter
// Shares one Huffman encoder between NUM_REQ requesters. Jobs are accepted
// round-robin, loaded into the encoder, run with a timeout, and the captured
// encodings are returned tagged with the requester id. One job in flight.
//
// Ports
//   clk, reset               : clock, async active-high reset
//   req_valid / req_ready    : per-requester job handshake (ready one-hot)
//   req_data / req_freq      : per-requester characters and frequencies
//   resp_valid / resp_ready  : response handshake
//   resp_id                  : requester owning the response
//   resp_value / resp_mask   : captured encodings and valid-bit masks
//   resp_error               : job timed out (value/mask forced to zero)
//   enc_reset                : encoder synchronous reset
//   enc_data_in/enc_freq_in  : job presented to the encoder
//   enc_value/enc_mask/enc_done : encoder results
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | encoder parked in reset, waiting for any req_valid to grant
// KICK  | job latched, encoder held in reset one more cycle to sample it
// RUN   | encoder running, timer counting, waiting for a genuine done
// RESP  | response presented, encoder parked, waiting for resp_ready
// ----------------------------------------------------------------------------
module huff_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_CHAR_COUNT = huff_pkg::MAX_CHAR_COUNT,
    parameter int TIMEOUT_CYC    = 32,
    parameter int ID_W           = 2
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [NUM_REQ-1:0]                                           req_valid,
    output logic [NUM_REQ-1:0]                                           req_ready,
    input  logic [NUM_REQ-1:0][MAX_CHAR_COUNT-1:0][huff_pkg::BIT_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0][MAX_CHAR_COUNT-1:0][huff_pkg::FREQ_W-1:0]    req_freq,
    output logic                                                         resp_valid,
    input  logic                                                         resp_ready,
    output logic [ID_W-1:0]                                              resp_id,
    output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]                resp_value,
    output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]                resp_mask,
    output logic                                                         resp_error,
    output logic                                                         enc_reset,
    output logic [MAX_CHAR_COUNT-1:0][huff_pkg::BIT_WIDTH-1:0]           enc_data_in,
    output logic [MAX_CHAR_COUNT-1:0][huff_pkg::FREQ_W-1:0]              enc_freq_in,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]                enc_value,
    input  logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]                enc_mask,
    input  logic                                                         enc_done
);

    import huff_pkg::*;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    arb_state_t state_q;
    huff_job_t  job_q;
    logic [ID_W-1:0]  ptr_q;
    logic [ID_W-1:0]  ptr_d;
    logic [TMR_W-1:0] timer_q;
    logic             resp_valid_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] resp_value_q;
    logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0] resp_mask_q;
    logic             resp_error_q;
    logic             enc_reset_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    // The grant must be combinational so the requester sees ready in the
    // same cycle its data is latched; it is held off while reset is asserted.
    assign req_ready = (state_q == IDLE && !reset) ? gnt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            job_q        <= '0;
            ptr_q        <= '0;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_value_q <= '0;
            resp_mask_q  <= '0;
            resp_error_q <= 1'b0;
            enc_reset_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    enc_reset_q <= 1'b1;
                    if (gnt_valid) begin
                        job_q.data <= req_data[gnt_idx];
                        job_q.freq <= req_freq[gnt_idx];
                        resp_id_q  <= gnt_idx;
                        ptr_q      <= ptr_d;
                        timer_q    <= '0;
                        state_q    <= KICK;
                    end
                end
                KICK: begin
                    // enc_reset was high through this cycle, so the encoder
                    // samples reset with the new job already on its inputs.
                    enc_reset_q <= 1'b0;
                    state_q     <= RUN;
                end
                RUN: begin
                    // timer_q == 0 marks the first RUN cycle, where enc_done
                    // still reflects the previous job.
                    if (timer_q != '0 && enc_done) begin
                        resp_value_q <= enc_value;
                        resp_mask_q  <= enc_mask;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        enc_reset_q  <= 1'b1;
                        state_q      <= RESP;
                    end else if (timer_q == TMR_LAST) begin
                        resp_value_q <= '0;
                        resp_mask_q  <= '0;
                        resp_error_q <= 1'b1;
                        resp_valid_q <= 1'b1;
                        enc_reset_q  <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                RESP: begin
                    enc_reset_q <= 1'b1;
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_value  = resp_value_q;
    assign resp_mask   = resp_mask_q;
    assign resp_error  = resp_error_q;
    assign enc_reset   = enc_reset_q;
    assign enc_data_in = job_q.data;
    assign enc_freq_in = job_q.freq;

endmodule
